alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default 3, giving the width of the alu_control input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation.
REQ-006 The block SHALL have port alu_control, input, CTRL_WIDTH bits: operation code from the ALU decoder.
REQ-007 The block SHALL have ports src_a and src_b, input, WIDTH bits each: the operands.
REQ-008 The block SHALL have port result, output, WIDTH bits: the registered result.
REQ-009 The block SHALL have port zero, output, 1 bit: registered flag, high when result equals 0.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.

Function
REQ-012 Operation codes SHALL be: 000 AND, 001 OR, 010 ADD, 100 SUB, 110 SLT, 101 MUL; codes 011 and 111 SHALL behave as ADD.
REQ-013 The state machine SHALL have two states, IDLE and MUL; start is accepted only in IDLE and is ignored in MUL.
REQ-014 Operands and alu_control SHALL be captured at the accepting edge; input changes after that edge SHALL NOT affect the operation in flight.
REQ-015 A non-MUL operation accepted at edge k SHALL write result and zero, and assert done, at edge k; the block SHALL stay in IDLE, so latency is 1 cycle.
REQ-016 ADD and SUB SHALL use modulo-2^WIDTH two's-complement wrap with no overflow indication.
REQ-017 SLT SHALL give 1 when src_a is less than src_b as signed values, and 0 otherwise, zero-extended to WIDTH.
REQ-018 MUL accepted at edge k SHALL move to MUL, clear a counter and run one shift-add step per edge for WIDTH edges.
REQ-019 At edge k+WIDTH, MUL SHALL write the low WIDTH bits of the product, assert done and return to IDLE.
REQ-020 The MUL result SHALL be the same for signed and unsigned interpretation of the operands.
REQ-021 busy SHALL be high exactly while the state is MUL: WIDTH cycles per multiply and never during single-cycle operations.
REQ-022 done SHALL be high for exactly one cycle per completed operation; a start in the cycle that done is high SHALL be accepted.
REQ-023 result and zero SHALL hold their last value until the next completion.
REQ-024 A start with the same operation repeated every cycle SHALL complete once per cycle for non-MUL operations.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL set state to IDLE and clear result, busy, done and the counter.
REQ-026 While rst_n is low at a clock edge, zero SHALL be set to 1, consistent with result equal to 0.
REQ-027 Reset during MUL SHALL abort the multiply with no done pulse.
REQ-028 start SHALL be ignored while rst_n is low.

Configuration
REQ-029 With macro ALU_SEQ_MUL_EN defined, MUL SHALL be implemented as specified in REQ-018 to REQ-020.
REQ-030 Without ALU_SEQ_MUL_EN, code 101 SHALL complete in 1 cycle with result 0, zero 1 and busy never asserted, and no multiplier logic SHALL be generated.

Verification
REQ-031 With WIDTH 32, the bench SHALL cover these cases:
- ADD 5, 7 -> result 12, zero 0, done one cycle after start.
- SUB 3, 5 -> 0xFFFFFFFE.
- SUB 9, 9 -> result 0, zero 1.
- SLT 0xFFFFFFFF, 1 -> result 1.
- SLT 1, 0xFFFFFFFF -> result 0.
- AND 0xF0F0, 0xFF00 -> 0xF000.
- OR 0xF0F0, 0xFF00 -> 0xFFF0.
REQ-032 MUL 0x1234, 0x10 SHALL give busy high for 32 cycles, then result 0x00012340 with a single done pulse.
- MUL 0xFFFFFFFF, 0xFFFFFFFF -> 0x00000001.
REQ-033 During a MUL, the bench SHALL toggle start, src_a and src_b every cycle; the result SHALL be unchanged and no extra done SHALL occur.
- A start in the done cycle SHALL begin the next operation immediately.
REQ-034 The bench SHALL drive rst_n low 10 cycles into a MUL:
- Response: busy 0, result 0, zero 1, no done.
- A following ADD 1, 1 -> 2 after 1 cycle.
REQ-035 With ALU_SEQ_MUL_EN undefined, MUL 6, 7 SHALL give result 0 with done after 1 cycle and busy staying 0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle AND/OR/ADD/SUB/SLT and an optional WIDTH-cycle shift-add multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise code 101 completes at once with result 0.
module alu_seq #(
   parameter int WIDTH      = 32,
   parameter int CTRL_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CTRL_WIDTH-1:0] alu_control,
   input  logic [WIDTH-1:0]      src_a,
   input  logic [WIDTH-1:0]      src_b,
   output logic [WIDTH-1:0]      result,
   output logic                  zero,
   output logic                  busy,
   output logic                  done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] MUL  = 1'b1;

   localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(0);
   localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(1);
   localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(2);
   localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(4);
   localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(5);
   localparam logic [CTRL_WIDTH-1:0] OP_SLT = CTRL_WIDTH'(6);

   logic [0:0]       state;
   logic [WIDTH-1:0] alu_out;
   logic             slt_bit;

   assign slt_bit = $signed(src_a) < $signed(src_b);
   assign busy    = (state == MUL);

   // Unused codes fall through to ADD; MUL yields 0 here, which is the result when the multiplier is absent.
   always_comb begin
      alu_out = src_a + src_b;
      case (alu_control)
         OP_AND:  alu_out = src_a & src_b;
         OP_OR:   alu_out = src_a | src_b;
         OP_ADD:  alu_out = src_a + src_b;
         OP_SUB:  alu_out = src_a - src_b;
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_MUL:  alu_out = '0;
         default: alu_out = src_a + src_b;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] count;

   // Low WIDTH bits of the product are identical for signed and unsigned operands, so plain shift-add suffices.
   assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         result <= '0;
         zero   <= 1'b1;
         done   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
`ifdef ALU_SEQ_MUL_EN
               if (alu_control == OP_MUL) begin
                  state  <= MUL;
                  count  <= '0;
                  acc    <= '0;
                  mcand  <= src_a;
                  mplier <= src_b;
               end else begin
                  result <= alu_out;
                  zero   <= (alu_out == '0);
                  done   <= 1'b1;
               end
`else
               result <= alu_out;
               zero   <= (alu_out == '0);
               done   <= 1'b1;
`endif
            end
         end else begin
`ifdef ALU_SEQ_MUL_EN
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (count == LAST_STEP) begin
               result <= acc_next;
               zero   <= (acc_next == '0);
               done   <= 1'b1;
               state  <= IDLE;
            end
`else
            state <= IDLE;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expectations, a negedge monitor checks each done.
// Expectations for code 101 follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

   localparam int WIDTH = 32;
`ifdef ALU_SEQ_MUL_EN
   localparam int MUL_LAT = WIDTH;
`else
   localparam int MUL_LAT = 0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [2:0]       alu_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;
   logic             done;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      int          cyc;
      int          busy_n;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   busy_cnt = 0;
   int   checks   = 0;
   int   errors   = 0;

   alu_seq #(.WIDTH(WIDTH), .CTRL_WIDTH(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .result      (result),
      .zero        (zero),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Called just after a rising edge; the op is accepted on the next edge and completes lat edges later.
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_res, input int lat, input string name);
      exp_t e;
      start       = 1'b1;
      alu_control = op;
      src_a       = a;
      src_b       = b;
      e.name   = name;
      e.res    = exp_res;
      e.zero   = (exp_res == 32'd0);
      e.cyc    = cyc + 1 + lat;
      e.busy_n = lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            check_output({e.name, "_result"}, result, e.res);
            check_output({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
            check_output({e.name, "_done_cycle"}, cyc, e.cyc);
            check_output({e.name, "_busy_cycles"}, busy_cnt, e.busy_n);
         end
         busy_cnt = 0;
      end
   end

   initial begin
      int waited;
      rst_n       = 1'b0;
      start       = 1'b1;
      alu_control = 3'b010;
      src_a       = 32'd5;
      src_b       = 32'd7;
      idle(3);
      check_output("reset_result", result, 32'd0);
      check_output("reset_zero", {31'd0, zero}, 32'd1);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      idle(2);

      apply_stimulus(3'b010, 32'd5, 32'd7, 32'd12, 0, "add_5_7");
      idle(1);
      apply_stimulus(3'b100, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, "sub_3_5");
      apply_stimulus(3'b100, 32'd9, 32'd9, 32'd0, 0, "sub_9_9");
      apply_stimulus(3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, "slt_neg1_1");
      apply_stimulus(3'b110, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, "slt_1_neg1");
      apply_stimulus(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, "and");
      apply_stimulus(3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, "or");
      apply_stimulus(3'b011, 32'd10, 32'd20, 32'd30, 0, "code011_add");
      apply_stimulus(3'b111, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, "code111_add");
      apply_stimulus(3'b010, 32'd1, 32'd2, 32'd3, 0, "rep_add_a");
      apply_stimulus(3'b010, 32'd3, 32'd4, 32'd7, 0, "rep_add_b");
      apply_stimulus(3'b010, 32'd100, 32'd200, 32'd300, 0, "rep_add_c");
      idle(2);

`ifdef ALU_SEQ_MUL_EN
      // Inputs churn for the whole multiply; the in-flight operands must not change.
      apply_stimulus(3'b101, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, MUL_LAT, "mul_1234_10");
      for (int i = 0; i < WIDTH; i++) begin
         start       = i[0];
         alu_control = i[2:0];
         src_a       = 32'hA5A5_0000 ^ i;
         src_b       = 32'h0F0F_1111 + i;
         @(posedge clk);
         #1;
      end
      apply_stimulus(3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, "add_in_done_cycle");
      idle(1);
      apply_stimulus(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT, "mul_neg1_neg1");
      idle(MUL_LAT + 1);
      apply_stimulus(3'b101, 32'h0001_0000, 32'h0001_0000, 32'd0, MUL_LAT, "mul_wrap_zero");
      idle(MUL_LAT + 1);

      apply_stimulus(3'b010, 32'd40, 32'd2, 32'd42, 0, "add_before_abort");
      apply_stimulus(3'b101, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, MUL_LAT, "mul_aborted");
      idle(9);
      rst_n = 1'b0;
      start = 1'b1;
      exp_q.pop_back();
      idle(1);
      check_output("abort_busy", {31'd0, busy}, 32'd0);
      check_output("abort_result", result, 32'd0);
      check_output("abort_zero", {31'd0, zero}, 32'd1);
      check_output("abort_done", {31'd0, done}, 32'd0);
      idle(1);
      rst_n = 1'b1;
      start = 1'b0;
      idle(1);
      apply_stimulus(3'b010, 32'd1, 32'd1, 32'd2, 0, "add_after_abort");
`else
      apply_stimulus(3'b101, 32'd6, 32'd7, 32'd0, MUL_LAT, "mul_disabled_6_7");
      apply_stimulus(3'b101, 32'h0000_1234, 32'h0000_0010, 32'd0, MUL_LAT, "mul_disabled_1234");
      apply_stimulus(3'b010, 32'd1, 32'd1, 32'd2, 0, "add_after_mul_disabled");
`endif

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      idle(3);
      check_output("pending_results", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
